// File: rtl/sd_sector_bridge_pkg.sv
// rtl/sd_sector_bridge_pkg.sv - shared constants and types for the SD sector bridge
package sd_sector_bridge_pkg;

  localparam int SECTOR_BYTES = 512;

  localparam logic [11:0] REG_LBA    = 12'h200;
  localparam logic [11:0] REG_CMD    = 12'h204;
  localparam logic [11:0] REG_STATUS = 12'h208;
  localparam logic [11:0] REG_CLEAR  = 12'h20C;

  localparam logic [31:0] CMD_READ  = 32'd1;
  localparam logic [31:0] CMD_WRITE = 32'd2;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_READY = 1;
  localparam int STAT_ERR   = 2;
  localparam int STAT_DONE  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  function automatic logic is_buf_addr(input logic [11:0] addr);
    return addr < 12'(SECTOR_BYTES);
  endfunction

endpackage

// File: rtl/sd_sector_ram.sv
// rtl/sd_sector_ram.sv - 512x8 sector buffer
// Single port, synchronous read with one cycle of latency.
module sd_sector_ram
  import sd_sector_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [8:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata_q
);

  logic [7:0] mem [SECTOR_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

endmodule

// File: rtl/sd_sector_bridge.sv
// rtl/sd_sector_bridge.sv - bus-mapped sector buffer driving a byte-wide SD controller
// The bus owns the buffer while idle; the transfer FSM owns it otherwise.
module sd_sector_bridge
  import sd_sector_bridge_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wen,
  input  logic [11:0] a,
  input  logic [31:0] d,
  output logic [31:0] q,
  output logic        ack,
  output logic        irq,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [31:0] sd_address,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout,
  input  logic        sd_byte_available,
  input  logic        sd_ready_for_next_byte,
  input  logic        sd_ready
);

  state_e      state_q, state_d;
  logic [8:0]  ptr_q, ptr_d;
  logic [11:0] count_q, count_d;
  logic [23:0] wd_q, wd_d;
  logic [31:0] lba_q, lba_d;
  logic [31:0] addr_q, addr_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        sd_rd_q, sd_rd_d;
  logic        sd_wr_q, sd_wr_d;
  logic        op_wr_q, op_wr_d;
  logic        cmd_seen_q, cmd_seen_d;
  logic        ack_q, ack_d;
  logic        rd_buf_q, rd_buf_d;
  logic [31:0] rdata_q, rdata_d;
  logic        avail_prev_q, rnb_prev_q, rdy_prev_q;

  logic        ram_we;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic        idle;
  logic        byte_rise, rnb_rise, rdy_rise;
  logic        cmd_wr;
  logic [8:0]  ptr_inc;
  logic [11:0] count_inc;

  assign idle      = (state_q == ST_IDLE);
  assign byte_rise = sd_byte_available & ~avail_prev_q;
  assign rnb_rise  = sd_ready_for_next_byte & ~rnb_prev_q;
  assign rdy_rise  = sd_ready & ~rdy_prev_q;
  assign cmd_wr    = req & wen & (a == REG_CMD) & ((d == CMD_READ) | (d == CMD_WRITE));
  assign ptr_inc   = (ptr_q == 9'(SECTOR_BYTES - 1)) ? ptr_q : ptr_q + 9'd1;
  assign count_inc = (&count_q) ? count_q : count_q + 12'd1;

  sd_sector_ram u_ram (
    .clk    (clk),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (ram_wdata),
    .rdata_q(ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    count_d    = count_q;
    wd_d       = wd_q;
    lba_d      = lba_q;
    addr_d     = addr_q;
    done_d     = done_q;
    err_d      = err_q;
    sd_rd_d    = sd_rd_q;
    sd_wr_d    = sd_wr_q;
    op_wr_d    = op_wr_q;
    cmd_seen_d = cmd_seen_q;
    ack_d      = req;
    rd_buf_d   = 1'b0;
    rdata_d    = 32'd0;
    ram_we     = 1'b0;
    ram_addr   = ptr_q;
    ram_wdata  = sd_dout;

    if (req) begin
      if (wen) begin
        if (a == REG_LBA) lba_d = d;
        if (a == REG_CLEAR) begin
          done_d = 1'b0;
          err_d  = 1'b0;
        end
      end else if (is_buf_addr(a)) begin
        rd_buf_d = idle;
      end else begin
        case (a)
          REG_LBA:    rdata_d = lba_q;
          REG_STATUS: begin
            rdata_d[STAT_BUSY]  = ~idle;
            rdata_d[STAT_READY] = sd_ready;
            rdata_d[STAT_ERR]   = err_q;
            rdata_d[STAT_DONE]  = done_q;
          end
          default:    rdata_d = 32'd0;
        endcase
      end
    end

    if (idle) begin
      ram_addr  = a[8:0];
      ram_wdata = d[7:0];
      ram_we    = req & wen & is_buf_addr(a);
    end

    if (cmd_wr && !idle) err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_wr) begin
          if (sd_ready) begin
            state_d    = ST_ISSUE;
            ptr_d      = 9'd0;
            count_d    = 12'd0;
            wd_d       = 24'd0;
            done_d     = 1'b0;
            cmd_seen_d = 1'b0;
            addr_d     = lba_q;
            op_wr_d    = (d == CMD_WRITE);
            sd_wr_d    = (d == CMD_WRITE);
            sd_rd_d    = (d == CMD_READ);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (!sd_ready) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        // The controller's first write-byte request belongs to its command phase.
        if (op_wr_q) begin
          if (rnb_rise) begin
            if (!cmd_seen_q) begin
              cmd_seen_d = 1'b1;
            end else begin
              ptr_d   = ptr_inc;
              count_d = count_inc;
            end
          end
        end else if (byte_rise) begin
          ram_we  = (count_q < 12'(SECTOR_BYTES));
          ptr_d   = ptr_inc;
          count_d = count_inc;
        end
        if (rdy_rise) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        if (count_q != 12'(SECTOR_BYTES)) err_d = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_ISSUE || state_q == ST_XFER) begin
      if (wd_q + 24'd1 == TIMEOUT_CYCLES) begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        sd_rd_d = 1'b0;
        sd_wr_d = 1'b0;
        state_d = ST_IDLE;
      end else begin
        wd_d = wd_q + 24'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= 9'd0;
      count_q      <= 12'd0;
      wd_q         <= 24'd0;
      lba_q        <= 32'd0;
      addr_q       <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      op_wr_q      <= 1'b0;
      cmd_seen_q   <= 1'b0;
      ack_q        <= 1'b0;
      rd_buf_q     <= 1'b0;
      rdata_q      <= 32'd0;
      avail_prev_q <= 1'b0;
      rnb_prev_q   <= 1'b0;
      rdy_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      wd_q         <= wd_d;
      lba_q        <= lba_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sd_rd_q      <= sd_rd_d;
      sd_wr_q      <= sd_wr_d;
      op_wr_q      <= op_wr_d;
      cmd_seen_q   <= cmd_seen_d;
      ack_q        <= ack_d;
      rd_buf_q     <= rd_buf_d;
      rdata_q      <= rdata_d;
      avail_prev_q <= sd_byte_available;
      rnb_prev_q   <= sd_ready_for_next_byte;
      rdy_prev_q   <= sd_ready;
    end
  end

  // Buffer reads arrive straight from the RAM's registered output in the ack cycle.
  assign q          = ack_q ? (rd_buf_q ? {24'd0, ram_rdata} : rdata_q) : 32'd0;
  assign ack        = ack_q;
  assign irq        = done_q;
  assign sd_rd      = sd_rd_q;
  assign sd_wr      = sd_wr_q;
  assign sd_address = addr_q;
  assign sd_din     = (op_wr_q && !idle) ? ram_rdata : 8'd0;

endmodule

// File: tb/tb_sd_sector_bridge.sv
// tb/tb_sd_sector_bridge.sv - directed bench for sd_sector_bridge
// A second instance with a short watchdog covers the timeout path.
module tb_sd_sector_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req2, wen;
  logic [11:0] a;
  logic [31:0] d;
  logic [7:0]  sd_dout;
  logic        sd_byte_available, sd_ready_for_next_byte, sd_ready, sd_ready2;

  logic [31:0] q, q2, sd_address, sd_address2;
  logic        ack, ack2, irq, irq2, sd_rd, sd_rd2, sd_wr, sd_wr2;
  logic [7:0]  sd_din, sd_din2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sd_sector_bridge #(.TIMEOUT_CYCLES(24'd4000)) dut (
    .clk(clk), .reset(reset), .req(req), .wen(wen), .a(a), .d(d),
    .q(q), .ack(ack), .irq(irq), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_address(sd_address), .sd_din(sd_din), .sd_dout(sd_dout),
    .sd_byte_available(sd_byte_available),
    .sd_ready_for_next_byte(sd_ready_for_next_byte), .sd_ready(sd_ready)
  );

  sd_sector_bridge #(.TIMEOUT_CYCLES(24'd1000)) dut_to (
    .clk(clk), .reset(reset), .req(req2), .wen(wen), .a(a), .d(d),
    .q(q2), .ack(ack2), .irq(irq2), .sd_rd(sd_rd2), .sd_wr(sd_wr2),
    .sd_address(sd_address2), .sd_din(sd_din2), .sd_dout(8'd0),
    .sd_byte_available(1'b0), .sd_ready_for_next_byte(1'b0), .sd_ready(sd_ready2)
  );

  typedef struct {
    logic        rdy;
    logic        w;
    logic [11:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [11:0] addr, input logic [31:0] data,
                     output logic [31:0] rd, output logic ackd);
    req = 1'b1; wen = w; a = addr; d = data;
    @(posedge clk);
    @(negedge clk);
    rd = q; ackd = ack;
    req = 1'b0; wen = 1'b0;
  endtask

  task automatic bus_wr(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic        ak;
    bus(1'b1, addr, data, rd, ak);
    chk("wr ack", {31'd0, ak}, 32'd1);
  endtask

  task automatic bus_rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ak;
    bus(1'b0, addr, 32'd0, rd, ak);
    chk({name, " ack"}, {31'd0, ak}, 32'd1);
    chk(name, rd, exp);
  endtask

  task automatic issue_handshake(input string tag);
    sd_ready = 1'b0;
    for (int t = 0; t < 50 && (sd_rd || sd_wr); t++) @(negedge clk);
    chk({tag, " strobe drop"}, {30'd0, sd_rd, sd_wr}, 32'd0);
  endtask

  task automatic finish_xfer(input string tag);
    sd_ready = 1'b1;
    for (int t = 0; t < 50 && !irq; t++) @(negedge clk);
    chk({tag, " irq"}, {31'd0, irq}, 32'd1);
  endtask

  task automatic model_read(input int nbytes, input logic [7:0] mask, input bit inject);
    for (int i = 0; i < nbytes; i++) begin
      sd_dout = 8'(i) ^ mask;
      sd_byte_available = 1'b1;
      @(negedge clk);
      sd_byte_available = 1'b0;
      if (inject && i == 100) begin
        bus_wr(12'h204, 32'd2);
        bus_rd_chk("busy buf rd", 12'h005, 32'd0);
        bus_wr(12'h032, 32'h0000_00EE);
      end
      @(negedge clk);
    end
  endtask

  task automatic model_write();
    sd_ready_for_next_byte = 1'b1;
    @(negedge clk);
    sd_ready_for_next_byte = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 512; j++) begin
      chk("wr byte", {24'd0, sd_din}, {24'd0, ~8'(j)});
      sd_ready_for_next_byte = 1'b1;
      @(negedge clk);
      sd_ready_for_next_byte = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_buf(input logic [7:0] mask);
    for (int k = 0; k < 512; k++) begin
      bus_rd_chk("buf rd", 12'(k), {24'd0, 8'(k) ^ mask});
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " q"}, q, 32'd0);
    chk({tag, " ack/irq/rd/wr"}, {28'd0, ack, irq, sd_rd, sd_wr}, 32'd0);
    chk({tag, " sd_address"}, sd_address, 32'd0);
    chk({tag, " sd_din"}, {24'd0, sd_din}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; req2 = 1'b0; wen = 1'b0; a = 12'd0; d = 32'd0;
    sd_dout = 8'd0; sd_byte_available = 1'b0; sd_ready_for_next_byte = 1'b0;
    sd_ready = 1'b1; sd_ready2 = 1'b1;

    vt[0]  = '{1'b1, 1'b1, 12'h200, 32'h1234_5678, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 12'h200, 32'h0, 32'h1234_5678};
    vt[2]  = '{1'b1, 1'b0, 12'h208, 32'h0, 32'h2};
    vt[3]  = '{1'b1, 1'b1, 12'h005, 32'hABCD_EF5A, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 12'h005, 32'h0, 32'h5A};
    vt[5]  = '{1'b1, 1'b1, 12'h1FF, 32'h77, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 12'h1FF, 32'h0, 32'h77};
    vt[7]  = '{1'b1, 1'b0, 12'h204, 32'h0, 32'h0};
    vt[8]  = '{1'b1, 1'b1, 12'h204, 32'h3, 32'h0};
    vt[9]  = '{1'b1, 1'b0, 12'h208, 32'h0, 32'h2};
    vt[10] = '{1'b0, 1'b1, 12'h204, 32'h1, 32'h0};
    vt[11] = '{1'b0, 1'b0, 12'h208, 32'h0, 32'h4};
    vt[12] = '{1'b0, 1'b1, 12'h20C, 32'h0, 32'h0};
    vt[13] = '{1'b0, 1'b0, 12'h208, 32'h0, 32'h0};
    vt[14] = '{1'b1, 1'b1, 12'h200, 32'h10, 32'h0};
    vt[15] = '{1'b1, 1'b0, 12'h200, 32'h0, 32'h10};
    vt[16] = '{1'b1, 1'b0, 12'h400, 32'h0, 32'h0};
    vt[17] = '{1'b1, 1'b0, 12'h208, 32'h0, 32'h2};

    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset dut_to", {30'd0, irq2, sd_rd2}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      logic [31:0] rd;
      logic        ak;
      sd_ready = vt[i].rdy;
      bus(vt[i].w, vt[i].addr, vt[i].data, rd, ak);
      chk($sformatf("vec%0d ack", i), {31'd0, ak}, 32'd1);
      if (!vt[i].w) chk($sformatf("vec%0d q", i), rd, vt[i].exp);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d ack drop", i), {31'd0, ack}, 32'd0);
    end
    sd_ready = 1'b1;

    bus_wr(12'h204, 32'd1);
    chk("rd start", {30'd0, sd_rd, sd_wr}, 32'd2);
    chk("rd lba", sd_address, 32'h10);
    issue_handshake("rd");
    model_read(512, 8'h00, 1'b0);
    finish_xfer("rd");
    bus_rd_chk("rd status", 12'h208, 32'hA);
    check_buf(8'h00);
    bus_wr(12'h20C, 32'd0);
    bus_rd_chk("clr status", 12'h208, 32'h2);

    bus_wr(12'h204, 32'd1);
    issue_handshake("busy");
    model_read(512, 8'h5A, 1'b1);
    finish_xfer("busy");
    bus_rd_chk("busy status", 12'h208, 32'hE);
    check_buf(8'h5A);
    bus_wr(12'h20C, 32'd0);

    for (int k = 0; k < 512; k++) bus_wr(12'(k), {24'hFFFFFF, ~8'(k)});
    bus_wr(12'h204, 32'd2);
    chk("wr start", {30'd0, sd_rd, sd_wr}, 32'd1);
    issue_handshake("wr");
    model_write();
    finish_xfer("wr");
    bus_rd_chk("wr status", 12'h208, 32'hA);
    bus_wr(12'h20C, 32'd0);

    bus_wr(12'h204, 32'd1);
    issue_handshake("short");
    model_read(500, 8'h00, 1'b0);
    finish_xfer("short");
    bus_rd_chk("short status", 12'h208, 32'hE);
    bus_wr(12'h20C, 32'd0);

    bus_wr(12'h204, 32'd1);
    issue_handshake("rst");
    model_read(200, 8'h00, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("midrst");
    reset = 1'b0;
    @(negedge clk);
    chk("midrst no strobe", {30'd0, sd_rd, sd_wr}, 32'd0);
    bus_rd_chk("midrst status", 12'h208, 32'h0);
    sd_ready = 1'b1;
    bus_wr(12'h204, 32'd1);
    chk("post rst start", {30'd0, sd_rd, sd_wr}, 32'd2);
    chk("post rst lba", sd_address, 32'd0);
    bus_rd_chk("post rst status", 12'h208, 32'h3);

    req2 = 1'b1; wen = 1'b1; a = 12'h204; d = 32'd1;
    @(posedge clk);
    @(negedge clk);
    chk("to ack", {31'd0, ack2}, 32'd1);
    chk("to start", {31'd0, sd_rd2}, 32'd1);
    req2 = 1'b0; wen = 1'b0;
    sd_ready2 = 1'b0;
    for (int k = 1; k < 1000; k++) @(posedge clk);
    @(negedge clk);
    chk("to before", {31'd0, irq2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("to at 1000", {30'd0, irq2, sd_rd2}, 32'd2);
    req2 = 1'b1; wen = 1'b0; a = 12'h208;
    @(posedge clk);
    @(negedge clk);
    chk("to status", q2, 32'hC);
    req2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
